// File: rtl/serial_read_buffer_pkg.sv
// Shared definitions for the serial read/write buffer pair: state numbering
// and the counter-width rule.
package serial_read_buffer_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_READ  = 2'd1;
  localparam logic [1:0] STATE_RESET = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_READ  = STATE_READ,
    ST_RESET = STATE_RESET
  } state_e;

  // Counter must be able to hold the value buf_size itself, not just buf_size-1.
  function automatic int ctr_width(input int buf_size);
    return $clog2(buf_size + 1);
  endfunction

endpackage

// File: rtl/serial_read_buffer_if.sv
// Parallel/serial handshake bundle between the bit-timing generator, the
// read buffer and the word consumer.
interface serial_read_buffer_if #(
  parameter int BUF_SIZE = 8
);
  logic                start;
  logic                abort;
  logic                read_sig;
  logic                data_in;
  logic [BUF_SIZE-1:0] data_out;
  logic                done_sig;

  modport master (
    output start, abort, read_sig, data_in,
    input  data_out, done_sig
  );

  modport slave (
    input  start, abort, read_sig, data_in,
    output data_out, done_sig
  );
endinterface

// File: rtl/serial_read_buffer.sv
// Deserialises BUF_SIZE bits MSB first, one per read_sig strobe; word and done_sig
// update one edge after the last sample. No backpressure: strobes outside a sequence are dropped.
module serial_read_buffer
  import serial_read_buffer_pkg::*;
#(
  parameter int BUF_SIZE = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  serial_read_buffer_if.slave   bus
);

  localparam int CTR_SIZE = ctr_width(BUF_SIZE);

  state_e              state_q,    state_d;
  logic [BUF_SIZE-1:0] read_buf_q, read_buf_d;
  logic [CTR_SIZE-1:0] buf_ctr_q,  buf_ctr_d;
  logic [BUF_SIZE-1:0] data_out_q, data_out_d;
  logic                done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    read_buf_d = read_buf_q;
    buf_ctr_d  = buf_ctr_q;
    data_out_d = data_out_q;
    done_d     = done_q;
    case (state_q)
      ST_RESET: begin
        read_buf_d = '0;
        buf_ctr_d  = '0;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.start) begin
          done_d     = 1'b0;
          read_buf_d = '0;
          buf_ctr_d  = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        // Abort outranks completion so a cancelled word never reaches data_out.
        if (bus.abort) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (buf_ctr_q == CTR_SIZE'(BUF_SIZE)) begin
          data_out_d = read_buf_q;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else if (bus.read_sig) begin
          read_buf_d = {read_buf_q[BUF_SIZE-2:0], bus.data_in};
          buf_ctr_d  = buf_ctr_q + CTR_SIZE'(1);
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      read_buf_q <= '0;
      buf_ctr_q  <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_buf_q <= read_buf_d;
      buf_ctr_q  <= buf_ctr_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done_sig = done_q;

endmodule
